spart_bus_arbiter: RTL and testbench
====================================

// Module: spart_bus_arbiter
// PURPOSE
//  Owns the SPART register bus (iocs/iorw/ioaddr/databus) and shares it between two requesters.
//  After reset, and on request, it first programs the baud divisor selected by br_cfg.
//  It then grants single-register transactions round-robin and returns read data with a per-requester ack.
//  Sits between client logic (e.g. TX feeder, RX drain) and the SPART.
// PARAMETERS
//  DIV_CFG0  16'h0516  divisor programmed when br_cfg==2'b00
//  DIV_CFG1  16'h028B  divisor programmed when br_cfg==2'b01
//  DIV_CFG2  16'h0146  divisor programmed when br_cfg==2'b10
//  DIV_CFG3  16'h00A3  divisor programmed when br_cfg==2'b11
// PORTS
//  clk         in     1  system clock, all logic on posedge
//  rst         in     1  synchronous reset, active-high
//  br_cfg      in     2  baud select; sampled on entry to INIT_LO
//  cfg_reload  in     1  one-cycle pulse: rerun divisor init after the current transaction
//  req0/req1   in     1  transaction request; held high until matching ack
//  rw0/rw1     in     1  1=read, 0=write
//  addr0/addr1 in     2  SPART register address (00 data, 01 status, 10 DB lo, 11 DB hi)
//  wdata0/1    in     8  write data
//  ack0/ack1   out    1  one-cycle completion pulse
//  rdata       out    8  read data; valid in the ack cycle, holds until next read
//  init_done   out    1  high once the divisor is programmed; low during INIT_*
//  tbr, rda    in     1  SPART status (transmit buffer ready, receive data available)
//  iocs        out    1  SPART chip select
//  iorw        out    1  1=read, 0=write
//  ioaddr      out    2  SPART register address
//  databus     inout  8  driven only when iocs=1 && iorw=0, else 8'hzz
// BEHAVIOUR
//  Reset values: iocs=0, iorw=1, ioaddr=2'b00, ack0=ack1=0, rdata=0, init_done=0,
//   rr_ptr=0 (requester 0 preferred), state=INIT_LO.
//  States:
//   - INIT_LO: iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0]; -> INIT_HI.
//   - INIT_HI: iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8]; -> IDLE; init_done<=1.
//   - IDLE: iocs=0. Reload pending: -> INIT_LO, init_done<=0.
//     Else arbitrate, latch rw/addr/wdata of winner; -> XFER. No request: stay.
//   - XFER: iocs=1, iorw/ioaddr/databus from latch. Read: rdata<=databus at end of cycle. -> ACK.
//   - ACK: iocs=0, ack of granted requester =1 for this cycle only; rr_ptr<=other requester; -> IDLE.
//  Latency: req high in IDLE -> bus cycle 1 clk later -> ack 2 clks after grant cycle; 3-cycle min period.
//  Arbitration: one request -> granted. Both -> requester rr_ptr wins; after a grant rr_ptr points to the loser.
//  Requests arriving during INIT_*/XFER/ACK wait; req dropped before grant is simply not served.
//  cfg_reload in any state sets a sticky pending flag, cleared on entry to INIT_LO; an
//   in-flight transaction always completes with its ack first. Reload has priority over pending requests.
//  Re-asserting cfg_reload during INIT_* re-arms the flag -> one more init pass.
//  rst mid-transaction: abort immediately, no ack issued, restart at INIT_LO.
//  Never more than one ack per cycle; never iocs=1 for two transactions back-to-back (ACK gap).
// CONFIGURATION
//  SPART_STATUS_GATE_EN defined: a request to addr 00 is eligible only if (rw=0 && tbr=1) or (rw=1 && rda=1);
//   ineligible request is skipped, other requester may be granted, rr_ptr unchanged when nothing granted.
//  Undefined: tbr/rda ignored; every request eligible; client checks status itself.
// TESTING
//  1 rst, br_cfg=01 -> INIT_LO ioaddr=10 data=8B, INIT_HI ioaddr=11 data=02, init_done=1 next cycle.
//  2 req0 write addr00 wdata=41 -> one XFER cycle iocs=1 iorw=0 databus=41, ack0 pulse 2 clks later.
//  3 req1 read addr00, SPART drives 5A -> ack1 with rdata=5A; databus not driven by arbiter.
//  4 req0,req1 held high continuously -> grants alternate 0,1,0,1; each ack exactly one cycle.
//  5 cfg_reload during XFER with br_cfg=11 -> ack completes, then A3/00 written, init_done low for 2 cycles.
//  6 (GATE_EN) req0 write addr00 with tbr=0, req1 read addr01 -> req1 served; req0 granted after tbr=1.

Source files
------------

// File: rtl/spart_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spart_bus_arbiter_if
// Client request/ack signals and the SPART control/status strobes.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface spart_bus_arbiter_if;
  logic [1:0] br_cfg;
  logic       cfg_reload;
  logic       req0;
  logic       req1;
  logic       rw0;
  logic       rw1;
  logic [1:0] addr0;
  logic [1:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       ack0;
  logic       ack1;
  logic [7:0] rdata;
  logic       init_done;
  logic       tbr;
  logic       rda;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  // Arbiter side: it masters the SPART register bus.
  modport master (
    input  br_cfg, cfg_reload,
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  tbr, rda,
    output ack0, ack1, rdata, init_done,
    output iocs, iorw, ioaddr
  );

  // Environment side: requesting clients plus the SPART itself.
  modport slave (
    output br_cfg, cfg_reload,
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output tbr, rda,
    input  ack0, ack1, rdata, init_done,
    input  iocs, iorw, ioaddr
  );
endinterface
`default_nettype wire

// File: rtl/spart_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spart_bus_arbiter
// Programs the SPART baud divisor, then shares the register bus between two
// requesters round-robin. Optional macro: SPART_STATUS_GATE_EN.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module spart_bus_arbiter #(
  parameter logic [15:0] DIV_CFG0 = 16'h0516,
  parameter logic [15:0] DIV_CFG1 = 16'h028B,
  parameter logic [15:0] DIV_CFG2 = 16'h0146,
  parameter logic [15:0] DIV_CFG3 = 16'h00A3
) (
  input  wire logic       clk,
  input  wire logic       rst,
  spart_bus_arbiter_if.master bus,
  inout  wire       [7:0] databus
);

  typedef enum logic [2:0] {
    ST_INIT_LO = 3'd0,
    ST_INIT_HI = 3'd1,
    ST_IDLE    = 3'd2,
    ST_XFER    = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_div;
  logic        r_pend;
  logic        r_rr_ptr;
  logic        r_gnt;
  logic        r_rw;
  logic [1:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_ack0;
  logic        r_ack1;
  logic [7:0]  r_rdata;
  logic        r_init_done;

  logic [15:0] w_div_sel;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_gnt_valid;
  logic        w_gnt_sel;
  logic        w_iocs;
  logic        w_iorw;
  logic [1:0]  w_ioaddr;
  logic [7:0]  w_dout;

  always_comb begin
    w_div_sel = DIV_CFG0;
    case (bus.br_cfg)
      2'b00:   w_div_sel = DIV_CFG0;
      2'b01:   w_div_sel = DIV_CFG1;
      2'b10:   w_div_sel = DIV_CFG2;
      default: w_div_sel = DIV_CFG3;
    endcase
  end

`ifdef SPART_STATUS_GATE_EN
  // Data-register accesses wait until the SPART can accept/supply a byte.
  assign w_elig0 = bus.req0 &&
                   ((bus.addr0 != 2'b00) || (bus.rw0 ? bus.rda : bus.tbr));
  assign w_elig1 = bus.req1 &&
                   ((bus.addr1 != 2'b00) || (bus.rw1 ? bus.rda : bus.tbr));
`else
  assign w_elig0 = bus.req0;
  assign w_elig1 = bus.req1;
`endif

  assign w_gnt_valid = w_elig0 | w_elig1;
  assign w_gnt_sel   = (w_elig0 && w_elig1) ? r_rr_ptr : w_elig1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT_LO;
      r_div       <= w_div_sel;
      r_pend      <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_gnt       <= 1'b0;
      r_rw        <= 1'b1;
      r_addr      <= 2'b00;
      r_wdata     <= 8'h00;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata     <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (bus.cfg_reload) begin
        r_pend <= 1'b1;
      end
      case (r_state)
        ST_INIT_LO: r_state <= ST_INIT_HI;
        ST_INIT_HI: begin
          r_state     <= ST_IDLE;
          r_init_done <= 1'b1;
        end
        ST_IDLE: begin
          if (r_pend) begin
            // A reload coinciding with entry re-arms for another pass.
            r_state     <= ST_INIT_LO;
            r_init_done <= 1'b0;
            r_pend      <= bus.cfg_reload;
            r_div       <= w_div_sel;
          end else if (w_gnt_valid) begin
            r_state <= ST_XFER;
            r_gnt   <= w_gnt_sel;
            r_rw    <= w_gnt_sel ? bus.rw1    : bus.rw0;
            r_addr  <= w_gnt_sel ? bus.addr1  : bus.addr0;
            r_wdata <= w_gnt_sel ? bus.wdata1 : bus.wdata0;
          end
        end
        ST_XFER: begin
          if (r_rw) begin
            r_rdata <= databus;
          end
          r_ack0  <= ~r_gnt;
          r_ack1  <= r_gnt;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          r_rr_ptr <= ~r_gnt;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus strobes decode straight from the state register so each bus phase
  // coincides with its state; held quiet while reset is asserted.
  always_comb begin
    w_iocs   = 1'b0;
    w_iorw   = 1'b1;
    w_ioaddr = 2'b00;
    w_dout   = 8'h00;
    if (!rst) begin
      case (r_state)
        ST_INIT_LO: begin
          w_iocs   = 1'b1;
          w_iorw   = 1'b0;
          w_ioaddr = 2'b10;
          w_dout   = r_div[7:0];
        end
        ST_INIT_HI: begin
          w_iocs   = 1'b1;
          w_iorw   = 1'b0;
          w_ioaddr = 2'b11;
          w_dout   = r_div[15:8];
        end
        ST_XFER: begin
          w_iocs   = 1'b1;
          w_iorw   = r_rw;
          w_ioaddr = r_addr;
          w_dout   = r_wdata;
        end
        default: begin
          w_iocs   = 1'b0;
          w_iorw   = 1'b1;
          w_ioaddr = 2'b00;
          w_dout   = 8'h00;
        end
      endcase
    end
  end

  assign databus       = (w_iocs && !w_iorw) ? w_dout : 8'hzz;
  assign bus.iocs      = w_iocs;
  assign bus.iorw      = w_iorw;
  assign bus.ioaddr    = w_ioaddr;
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata     = r_rdata;
  assign bus.init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_spart_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spart_bus_arbiter
// Directed stimulus with hand-computed expectations for spart_bus_arbiter.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_spart_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       spart_drv;
  logic [7:0] spart_val;
  wire  [7:0] databus;

  spart_bus_arbiter_if bus ();

  assign databus = spart_drv ? spart_val : 8'hzz;

  spart_bus_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .databus (databus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.br_cfg     = 2'b01;
    bus.cfg_reload = 1'b0;
    bus.req0       = 1'b0;
    bus.req1       = 1'b0;
    bus.rw0        = 1'b0;
    bus.rw1        = 1'b0;
    bus.addr0      = 2'b00;
    bus.addr1      = 2'b00;
    bus.wdata0     = 8'h00;
    bus.wdata1     = 8'h00;
    bus.tbr        = 1'b0;
    bus.rda        = 1'b0;
    spart_drv      = 1'b0;
    spart_val      = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_iocs", bus.iocs, 1'b0);
    check("rst_iorw", bus.iorw, 1'b1);
    check("rst_ioaddr", bus.ioaddr, 2'b00);
    check("rst_ack", {bus.ack1, bus.ack0}, 2'b00);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_init_done", bus.init_done, 1'b0);

    // Divisor init with br_cfg=01 -> 028B
    rst = 1'b0;
    #1;
    check("init_lo_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1010);
    check("init_lo_data", databus, 8'h8B);
    tick();
    check("init_hi_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1011);
    check("init_hi_data", databus, 8'h02);
    check("init_hi_done", bus.init_done, 1'b0);
    tick();
    check("idle_done", bus.init_done, 1'b1);
    check("idle_cs", bus.iocs, 1'b0);

    // Write from requester 0
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 2'b00; bus.wdata0 = 8'h41;
    tick();
    check("wr_xfer_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1000);
    check("wr_xfer_data", databus, 8'h41);
    check("wr_xfer_noack", bus.ack0, 1'b0);
    tick();
    check("wr_ack", {bus.ack1, bus.ack0}, 2'b01);
    check("wr_ack_cs", bus.iocs, 1'b0);
    bus.req0 = 1'b0;
    tick();
    check("wr_ack_once", {bus.ack1, bus.ack0}, 2'b00);

    // Read from requester 1, SPART supplies 5A
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 2'b00;
    spart_drv = 1'b1; spart_val = 8'h5A;
    tick();
    check("rd_xfer_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1100);
    tick();
    check("rd_ack", {bus.ack1, bus.ack0}, 2'b10);
    check("rd_data", bus.rdata, 8'h5A);
    bus.req1 = 1'b0;
    spart_drv = 1'b0;
    tick();
    check("rd_data_hold", bus.rdata, 8'h5A);

    // Both held: grants alternate starting with requester 0
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 2'b01; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 2'b01; bus.wdata1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_xfer_data%0d", k), databus, (k % 2 == 1) ? 8'h22 : 8'h11);
      tick();
      check($sformatf("rr_ack%0d", k), {bus.ack1, bus.ack0}, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      check($sformatf("rr_gap%0d", k), {bus.iocs, bus.ack1, bus.ack0}, 3'b000);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Reload during XFER with br_cfg=11; queued req1 waits behind the init
    bus.br_cfg = 2'b11;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 2'b01; bus.wdata0 = 8'h77;
    tick();
    check("rl_xfer_data", databus, 8'h77);
    bus.cfg_reload = 1'b1;
    tick();
    bus.cfg_reload = 1'b0;
    check("rl_ack", {bus.ack1, bus.ack0}, 2'b01);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 2'b10; bus.wdata1 = 8'h99;
    tick();
    check("rl_idle_done", bus.init_done, 1'b1);
    tick();
    check("rl_lo_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1010);
    check("rl_lo_data", databus, 8'hA3);
    check("rl_lo_done", bus.init_done, 1'b0);
    tick();
    check("rl_hi_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1011);
    check("rl_hi_data", databus, 8'h00);
    check("rl_hi_done", bus.init_done, 1'b0);
    tick();
    check("rl_idle2_done", bus.init_done, 1'b1);
    tick();
    check("rl_req1_data", databus, 8'h99);
    tick();
    check("rl_req1_ack", {bus.ack1, bus.ack0}, 2'b10);
    bus.req1 = 1'b0;
    tick();

    // Reset mid-transaction: no ack, restart init with br_cfg=11
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 2'b01; bus.wdata0 = 8'h55;
    tick();
    check("ab_xfer_cs", bus.iocs, 1'b1);
    rst = 1'b1;
    bus.req0 = 1'b0;
    tick();
    check("ab_noack", {bus.ack1, bus.ack0, bus.iocs}, 3'b000);
    tick();
    check("ab_noack2", {bus.ack1, bus.ack0, bus.init_done}, 3'b000);
    rst = 1'b0;
    #1;
    check("ab_lo_data", databus, 8'hA3);
    tick();
    check("ab_hi_data", databus, 8'h00);
    tick();
    check("ab_done", bus.init_done, 1'b1);

`ifdef SPART_STATUS_GATE_EN
    // req0 data write blocked by tbr=0; req1 status read served first
    bus.tbr = 1'b0; bus.rda = 1'b0;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 2'b00; bus.wdata0 = 8'h3C;
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 2'b01;
    tick();
    check("gate_req1_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1101);
    tick();
    check("gate_req1_ack", {bus.ack1, bus.ack0}, 2'b10);
    bus.req1 = 1'b0;
    bus.tbr = 1'b1;
    tick();
    tick();
    check("gate_req0_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1000);
    check("gate_req0_data", databus, 8'h3C);
    tick();
    check("gate_req0_ack", {bus.ack1, bus.ack0}, 2'b01);
    bus.req0 = 1'b0;
    tick();
`else
    // Status ignored: data write proceeds with tbr=0
    bus.tbr = 1'b0; bus.rda = 1'b0;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 2'b00; bus.wdata0 = 8'h3C;
    tick();
    check("nogate_cs", {bus.iocs, bus.iorw, bus.ioaddr}, 4'b1000);
    check("nogate_data", databus, 8'h3C);
    tick();
    check("nogate_ack", {bus.ack1, bus.ack0}, 2'b01);
    bus.req0 = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
